// File: rtl/access_assembler_pkg.sv
// rtl/access_assembler_pkg.sv - shared constants, opcodes and entry type for the access assembler
package access_assembler_pkg;

    localparam int NUM_INSTR  = 524;
    localparam int MEM_BLOCKS = 16384;
    localparam int BLOCK_SIZE = 64;
    localparam int SET_NUMBER = 64;

    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int SET_W  = $clog2(SET_NUMBER);
    localparam int ADDR_W = $clog2(MEM_BLOCKS) + OFF_W;
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
    localparam int CNT_W  = $clog2(NUM_INSTR + 1);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LD   = 4'd1,
        OP_ST   = 4'd2,
        OP_BASE = 4'd3,
        OP_ADDB = 4'd4
    } opcode_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              op;
        logic [CNT_W-1:0]  index;
    } entry_t;

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/access_assembler_decode.sv
// rtl/access_assembler_decode.sv - combinational opcode decode into emit/op/base-update/illegal flags
module access_assembler_decode
    import access_assembler_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       emit_o,
    output logic       op_o,
    output logic       base_load_o,
    output logic       base_add_o,
    output logic       illegal_o
);

    always_comb begin
        emit_o      = 1'b0;
        op_o        = 1'b0;
        base_load_o = 1'b0;
        base_add_o  = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OP_NOP:  ;
            OP_LD:   emit_o = 1'b1;
            OP_ST: begin
                emit_o = 1'b1;
                op_o   = 1'b1;
            end
            OP_BASE: base_load_o = 1'b1;
            OP_ADDB: base_add_o  = 1'b1;
            default: illegal_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/access_assembler.sv
// rtl/access_assembler.sv - assembles access words into cache-trace entries; optional ACCESS_ASSEMBLER_STATS_EN
module access_assembler
    import access_assembler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_op,
    output logic [TAG_W-1:0]  out_tag,
    output logic [SET_W-1:0]  out_set,
    output logic [OFF_W-1:0]  out_offset,
    output logic [CNT_W-1:0]  out_index,
    output logic              done,
    output logic              err
`ifdef ACCESS_ASSEMBLER_STATS_EN
    ,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
`endif
);

    entry_t            entry_q, entry_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              dec_emit, dec_op, dec_base_load, dec_base_add, dec_illegal;
    logic              accept, out_hs, load;
    logic [ADDR_W-1:0] imm;
    logic              unused_instr_bits;

    assign imm               = in_instr[ADDR_W-1:0];
    assign unused_instr_bits = ^in_instr[27:ADDR_W];

    access_assembler_decode u_decode (
        .opcode_i    (in_instr[31:28]),
        .emit_o      (dec_emit),
        .op_o        (dec_op),
        .base_load_o (dec_base_load),
        .base_add_o  (dec_base_add),
        .illegal_o   (dec_illegal)
    );

    always_comb begin
        out_hs   = valid_q & out_ready;
        in_ready = !done_q && (!valid_q || out_ready);
        accept   = in_valid & in_ready;
        count_d  = count_q + {{(CNT_W-1){1'b0}}, out_hs};
        done_d   = done_q | (out_hs && (count_q == CNT_W'(NUM_INSTR - 1)));
        // A word accepted on the final handshake is consumed but never presented.
        load     = accept & dec_emit & !done_d;

        valid_d = valid_q;
        if (load)
            valid_d = 1'b1;
        else if (out_hs)
            valid_d = 1'b0;

        entry_d = entry_q;
        if (load) begin
            entry_d.addr  = addr_add(base_q, imm);
            entry_d.op    = dec_op;
            entry_d.index = count_d;
        end

        base_d = base_q;
        if (accept && dec_base_load)
            base_d = imm;
        else if (accept && dec_base_add)
            base_d = addr_add(base_q, imm);

        err_d = err_q | (accept & dec_illegal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
            valid_q <= 1'b0;
            base_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            base_q  <= base_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_addr   = entry_q.addr;
    assign out_op     = entry_q.op;
    assign out_index  = entry_q.index;
    assign out_tag    = entry_q.addr[ADDR_W-1:SET_W+OFF_W];
    assign out_set    = entry_q.addr[SET_W+OFF_W-1:OFF_W];
    assign out_offset = entry_q.addr[OFF_W-1:0];
    assign done       = done_q;
    assign err        = err_q;

`ifdef ACCESS_ASSEMBLER_STATS_EN
    logic [CNT_W-1:0] rd_q, wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
            wr_q <= '0;
        end else if (out_hs) begin
            if (entry_q.op)
                wr_q <= wr_q + 1'b1;
            else
                rd_q <= rd_q + 1'b1;
        end
    end

    assign rd_count = rd_q;
    assign wr_count = wr_q;
`endif

endmodule

// File: tb/tb_access_assembler.sv
// tb/tb_access_assembler.sv - self-checking bench: vector table, corner sequences, randomized model compare
`timescale 1ns/1ps
module tb_access_assembler;
    import access_assembler_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr;
    logic              out_op;
    logic [TAG_W-1:0]  out_tag;
    logic [SET_W-1:0]  out_set;
    logic [OFF_W-1:0]  out_offset;
    logic [CNT_W-1:0]  out_index;
    logic              done;
    logic              err;
`ifdef ACCESS_ASSEMBLER_STATS_EN
    logic [CNT_W-1:0]  rd_count, wr_count;
`endif

    access_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_op     (out_op),
        .out_tag    (out_tag),
        .out_set    (out_set),
        .out_offset (out_offset),
        .out_index  (out_index),
        .done       (done),
        .err        (err)
`ifdef ACCESS_ASSEMBLER_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int addr;
        int op;
        int idx;
        int tag;
        int set;
        int off;
    } ent_t;

    ent_t        cap_q[$];
    ent_t        exp_q[$];
    logic [31:0] gen_q[$];
    bit          rnd_ready = 1'b0;

    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            cap_q.push_back('{int'(out_addr), int'(out_op), int'(out_index),
                              int'(out_tag), int'(out_set), int'(out_offset)});

    always @(posedge clk)
        if (rnd_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end

    function automatic logic [31:0] mk(input int opc, input logic [19:0] imm);
        logic [3:0] o;
        o = opc[3:0];
        return {o, 8'h00, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        cap_q.delete();
    endtask

    task automatic send(input logic [31:0] w, output bit acc);
        int n;
        bit r;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        forever begin
            @(negedge clk);
            r = in_ready;
            if (!r && done) break;
            @(posedge clk);
            #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
            n++;
            if (n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Reference: walk the word list with the opcode rules in plain integer arithmetic.
    task automatic model;
        int base;
        int opc;
        int imm;
        int a;
        base = 0;
        exp_q.delete();
        foreach (gen_q[i]) begin
            if (exp_q.size() == NUM_INSTR) break;
            opc = int'(gen_q[i][31:28]);
            imm = int'(gen_q[i][19:0]);
            if (opc == 1 || opc == 2) begin
                a = (base + imm) % (1 << ADDR_W);
                exp_q.push_back('{a, opc - 1, exp_q.size(), a / 4096, (a / 64) % 64, a % 64});
            end else if (opc == 3) begin
                base = imm;
            end else if (opc == 4) begin
                base = (base + imm) % (1 << ADDR_W);
            end
        end
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          addr;
        int          op;
        int          tag;
        int          set;
        int          off;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int bad;
        int n_rd;

        vecs[0] = '{mk(3, 20'h00000), mk(1, 20'h01A40), 'h01A40, 0, 'h01, 'h29, 'h00};
        vecs[1] = '{mk(3, 20'hFFFC0), mk(2, 20'h00080), 'h00040, 1, 'h00, 'h01, 'h00};
        vecs[2] = '{mk(3, 20'h12345), mk(1, 20'h00003), 'h12348, 0, 'h12, 'h0D, 'h08};
        vecs[3] = '{mk(4, 20'h00F00), mk(2, 20'h0000F), 'h13254, 1, 'h13, 'h09, 'h14};

        // Reset state
        do_reset;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);

        // Vector table: base setup word then one access, checked one cycle later
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].w0, acc);
            send(vecs[i].w1, acc);
            chk("vec_valid", out_valid, 1);
            chk("vec_addr", out_addr, vecs[i].addr);
            chk("vec_op", out_op, vecs[i].op);
            chk("vec_tag", out_tag, vecs[i].tag);
            chk("vec_set", out_set, vecs[i].set);
            chk("vec_offset", out_offset, vecs[i].off);
            chk("vec_index", out_index, i);
        end

        // Stall: consumer holds off for three cycles
        do_reset;
        out_ready = 1'b1;
        send(mk(3, 20'h0), acc);
        send(mk(1, 20'h00100), acc);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = mk(1, 20'h00200);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_addr_held", out_addr, 'h100);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) tick;
        chk("stall_entries", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            chk("stall_e0_addr", cap_q[0].addr, 'h100);
            chk("stall_e0_idx", cap_q[0].idx, 0);
            chk("stall_e1_addr", cap_q[1].addr, 'h200);
            chk("stall_e1_idx", cap_q[1].idx, 1);
        end

        // Illegal opcode between two loads
        do_reset;
        out_ready = 1'b1;
        send(mk(1, 20'h00005), acc);
        send(32'hF000_0000, acc);
        send(mk(1, 20'h00006), acc);
        repeat (3) tick;
        chk("illegal_err", err, 1);
        chk("illegal_entries", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            chk("illegal_e1_addr", cap_q[1].addr, 6);
            chk("illegal_e1_idx", cap_q[1].idx, 1);
        end

        // Asynchronous reset while an entry is stalled
        do_reset;
        out_ready = 1'b1;
        send(mk(3, 20'h01000), acc);
        out_ready = 1'b0;
        send(mk(1, 20'h00300), acc);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_index", out_index, 0);
        chk("async_rst_addr", out_addr, 0);
        tick;
        rst = 1'b0;
        tick;
        cap_q.delete();
        out_ready = 1'b1;
        send(mk(1, 20'h00055), acc);
        chk("post_rst_addr", out_addr, 'h55);
        chk("post_rst_index", out_index, 0);

        // Randomized run to completion against the reference model
        do_reset;
        gen_q.delete();
        begin
            int emits;
            int r;
            emits = 0;
            while (emits < NUM_INSTR + 6) begin
                r = $urandom_range(0, 9);
                if (r <= 3) begin
                    gen_q.push_back(mk(1, 20'($urandom)));
                    emits++;
                end else if (r <= 6) begin
                    gen_q.push_back(mk(2, 20'($urandom)));
                    emits++;
                end else if (r == 7) begin
                    gen_q.push_back(mk(3, 20'($urandom)));
                end else if (r == 8) begin
                    gen_q.push_back(mk(4, 20'($urandom)));
                end else begin
                    gen_q.push_back(mk(0, 20'($urandom)));
                end
            end
        end
        model;
        rnd_ready = 1'b1;
        foreach (gen_q[i]) begin
            if (done) break;
            send(gen_q[i], acc);
        end
        repeat (3) tick;
        rnd_ready = 1'b0;
        tick;
        chk("rand_done", done, 1);
        chk("rand_entry_count", cap_q.size(), NUM_INSTR);
        chk("rand_err", err, 0);
        bad = 0;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] != exp_q[i]) bad++;
        chk("rand_entries_mismatched", bad, 0);
        if (cap_q.size() > 0 && exp_q.size() > 0) begin
            chk("rand_first_addr", cap_q[0].addr, exp_q[0].addr);
            chk("rand_last_idx", cap_q[cap_q.size()-1].idx, NUM_INSTR - 1);
        end
        n_rd = 0;
        foreach (exp_q[i]) if (exp_q[i].op == 0) n_rd++;

        // Extra words after done are never accepted and produce nothing
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(1, 20'h00777);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_done_in_ready", in_ready, 0);
            chk("post_done_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("post_done_entries", cap_q.size(), NUM_INSTR);
        chk("post_done_sticky", done, 1);
`ifdef ACCESS_ASSEMBLER_STATS_EN
        chk("stats_sum", int'(rd_count) + int'(wr_count), NUM_INSTR);
        chk("stats_rd", rd_count, n_rd);
`endif
        if (n_rd < 0) chk("rd_count_sane", n_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
